// File: rtl/gf2n_pkg.sv
// GF(2^N) arithmetic helpers (N = 2 or 4, polynomial basis) and share-pair indexing
// for the DOM shared multipliers.
package gf2n_pkg;

    localparam int unsigned MaxN = 4;

    // Reduction terms: x^2 = x + 1 and x^4 = x + 1 (low bits of the irreducible polynomial).
    localparam logic [MaxN-1:0] Poly2 = 4'b0011;
    localparam logic [MaxN-1:0] Poly4 = 4'b0011;

    function automatic logic [MaxN-1:0] gf_poly(input int unsigned n);
        return (n == 2) ? Poly2 : Poly4;
    endfunction

    function automatic int unsigned npairs(input int unsigned shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Index of the unordered pair {i, j}, i != j, in the packed remask word list.
    function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned shares);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (2 * shares - lo - 1) / 2 + (hi - lo - 1);
    endfunction

    function automatic logic [MaxN-1:0] gf_mul(input logic [MaxN-1:0] a,
                                               input logic [MaxN-1:0] b,
                                               input int unsigned n);
        logic [MaxN-1:0] acc;
        logic [MaxN-1:0] sh;
        logic [MaxN-1:0] mask;
        logic [MaxN-1:0] top;
        logic [MaxN-1:0] poly;
        logic            carry;
        mask = MaxN'((32'd1 << n) - 32'd1);
        top  = MaxN'(32'd1 << (n - 1));
        poly = gf_poly(n) & mask;
        acc  = '0;
        sh   = a & mask;
        for (int unsigned k = 0; k < MaxN; k++) begin
            if (k < n) begin
                if (b[k]) acc = acc ^ sh;
                carry = |(sh & top);
                sh    = (sh << 1) & mask;
                if (carry) sh = sh ^ poly;
            end
        end
        return acc;
    endfunction

    function automatic logic [MaxN-1:0] gf_sq(input logic [MaxN-1:0] a, input int unsigned n);
        return gf_mul(a, a, n);
    endfunction

    function automatic logic [MaxN-1:0] gf_scale(input logic [MaxN-1:0] a,
                                                 input logic [MaxN-1:0] c,
                                                 input int unsigned n);
        return gf_mul(a, c, n);
    endfunction

endpackage

// File: rtl/shared_gf2n_mul_indep.sv
// Registered DOM-independent shared product X*B: every share pair (i, j) is one register,
// cross-domain terms remasked with the pair's Z word so the Z contributions cancel in the sum.
module shared_gf2n_mul_indep
    import gf2n_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned SHARES = 2
) (
    input  logic                        ClkxCI,
    input  logic                        RstxBI,
    input  logic                        EnxSI,
    input  logic [SHARES*N-1:0]         XxDI,
    input  logic [SHARES*N-1:0]         BxDI,
    input  logic [npairs(SHARES)*N-1:0] ZxDI,
    output logic [SHARES*N-1:0]         PxDO
);

    logic [N-1:0] term_d [SHARES][SHARES];
    logic [N-1:0] term_q [SHARES][SHARES];

    function automatic logic [N-1:0] mul_n(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(gf_mul(MaxN'(a), MaxN'(b), N));
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < SHARES; i++) begin
            for (int unsigned j = 0; j < SHARES; j++) begin
                term_d[i][j] = mul_n(XxDI[i*N +: N], BxDI[j*N +: N]);
                if (i != j) begin
                    term_d[i][j] = term_d[i][j] ^ ZxDI[pair_idx(i, j, SHARES)*N +: N];
                end
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            term_q <= '{default: '0};
        end else if (EnxSI) begin
            term_q <= term_d;
        end
    end

    // Share i collects only terms registered in its own domain.
    always_comb begin
        PxDO = '0;
        for (int unsigned i = 0; i < SHARES; i++) begin
            for (int unsigned j = 0; j < SHARES; j++) begin
                PxDO[i*N +: N] = PxDO[i*N +: N] ^ term_q[i][j];
            end
        end
    end

endmodule

// File: rtl/dom_dep_gf2n_mul_pipe.sv
// DOM-dependent shared GF(2^N) multiplier with valid/enable pipeline, optional output register
// and a per-beat fused square-scale mode: sum(Q) = X*Y ^ Mode*SCALE*(X^Y)^2.
module dom_dep_gf2n_mul_pipe
    import gf2n_pkg::*;
#(
    parameter int unsigned  N       = 2,
    parameter int unsigned  SHARES  = 2,
    parameter logic [N-1:0] SCALE   = (N == 4) ? N'(4'h9) : N'(2'b10),
    parameter bit           OUTREG  = 1'b0
) (
    input  logic                        ClkxCI,
    input  logic                        RstxBI,
    input  logic                        EnxSI,
    input  logic                        InValidxSI,
    input  logic                        ModexSI,
    input  logic [SHARES*N-1:0]         XxDI,
    input  logic [SHARES*N-1:0]         YxDI,
    input  logic [SHARES*N-1:0]         BxDI,
    input  logic [npairs(SHARES)*N-1:0] ZxDI,
    output logic [SHARES*N-1:0]         QxDO,
    output logic                        OutValidxSO
);

    localparam int unsigned W = SHARES * N;

    logic [W-1:0] x_q;
    logic [W-1:0] by_d;
    logic [W-1:0] by_q;
    logic [W-1:0] sqsc_d;
    logic [W-1:0] sqsc_q;
    logic         valid_q;
    logic [W-1:0] xb;
    logic [N-1:0] s;
    logic [W-1:0] q_comb;

    function automatic logic [N-1:0] mul_n(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(gf_mul(MaxN'(a), MaxN'(b), N));
    endfunction

    function automatic logic [N-1:0] sq_scale_n(input logic [N-1:0] a);
        return N'(gf_scale(gf_sq(MaxN'(a), N), MaxN'(SCALE), N));
    endfunction

    // Squaring and scaling are linear over GF(2), so the fused term is computed share-wise.
    always_comb begin
        by_d   = YxDI ^ BxDI;
        sqsc_d = '0;
        if (ModexSI) begin
            for (int unsigned i = 0; i < SHARES; i++) begin
                sqsc_d[i*N +: N] = sq_scale_n(XxDI[i*N +: N] ^ YxDI[i*N +: N]);
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            x_q     <= '0;
            by_q    <= '0;
            sqsc_q  <= '0;
            valid_q <= 1'b0;
        end else if (EnxSI) begin
            x_q     <= XxDI;
            by_q    <= by_d;
            sqsc_q  <= sqsc_d;
            valid_q <= InValidxSI;
        end
    end

    shared_gf2n_mul_indep #(
        .N      (N),
        .SHARES (SHARES)
    ) u_indep (
        .ClkxCI (ClkxCI),
        .RstxBI (RstxBI),
        .EnxSI  (EnxSI),
        .XxDI   (XxDI),
        .BxDI   (BxDI),
        .ZxDI   (ZxDI),
        .PxDO   (xb)
    );

    // S = Y ^ B is safe to unmask: B blinds Y and is removed again via the X*B term.
    always_comb begin
        s      = '0;
        q_comb = '0;
        for (int unsigned i = 0; i < SHARES; i++) begin
            s = s ^ by_q[i*N +: N];
        end
        for (int unsigned i = 0; i < SHARES; i++) begin
            q_comb[i*N +: N] = mul_n(x_q[i*N +: N], s) ^ xb[i*N +: N] ^ sqsc_q[i*N +: N];
        end
    end

    if (OUTREG) begin : g_outreg
        logic [W-1:0] q_q;
        logic         out_valid_q;

        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                q_q         <= '0;
                out_valid_q <= 1'b0;
            end else if (EnxSI) begin
                q_q         <= q_comb;
                out_valid_q <= valid_q;
            end
        end

        assign QxDO        = q_q;
        assign OutValidxSO = out_valid_q;
    end else begin : g_comb
        assign QxDO        = q_comb;
        assign OutValidxSO = valid_q;
    end

endmodule

// File: tb/tb_dom_dep_gf2n_mul_pipe.sv
// Directed bench: a 2-share GF(4) instance (no output register) and a 3-share GF(16)
// instance with output register, checked on the XOR of output shares.
module tb_dom_dep_gf2n_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;

    logic [3:0]  x2 = '0, y2 = '0, b2 = '0, q2;
    logic [1:0]  z2 = '0;
    logic        mode2 = 1'b0, vin2 = 1'b0, ov2;

    logic [11:0] x4 = '0, y4 = '0, b4 = '0, z4 = '0, q4;
    logic        mode4 = 1'b0, vin4 = 1'b0, ov4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [4:0]  vpat = 5'b01101;
    logic [4:0]  mpat = 5'b01010;
    logic [1:0]  st_x [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    logic [1:0]  st_e [5] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [3:0]  sweep_exp [256];
    logic [3:0]  xv, yv;
    logic [1:0]  r;

    always #5 clk = ~clk;

    dom_dep_gf2n_mul_pipe #(
        .N      (2),
        .SHARES (2),
        .SCALE  (2'b10),
        .OUTREG (1'b0)
    ) u_dut2 (
        .ClkxCI      (clk),
        .RstxBI      (rst_n),
        .EnxSI       (en),
        .InValidxSI  (vin2),
        .ModexSI     (mode2),
        .XxDI        (x2),
        .YxDI        (y2),
        .BxDI        (b2),
        .ZxDI        (z2),
        .QxDO        (q2),
        .OutValidxSO (ov2)
    );

    dom_dep_gf2n_mul_pipe #(
        .N      (4),
        .SHARES (3),
        .SCALE  (4'h9),
        .OUTREG (1'b1)
    ) u_dut4 (
        .ClkxCI      (clk),
        .RstxBI      (rst_n),
        .EnxSI       (en),
        .InValidxSI  (vin4),
        .ModexSI     (mode4),
        .XxDI        (x4),
        .YxDI        (y4),
        .BxDI        (b4),
        .ZxDI        (z4),
        .QxDO        (q4),
        .OutValidxSO (ov4)
    );

    function automatic logic [1:0] fold2(input logic [3:0] v);
        return v[1:0] ^ v[3:2];
    endfunction

    function automatic logic [3:0] fold4(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    // Schoolbook carry-less product, then reduction by x^4 + x + 1 from the top bit down.
    function automatic logic [3:0] ref_mul4(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = 7'd0;
        if (b[0]) p = p ^ {3'b000, a};
        if (b[1]) p = p ^ {2'b00, a, 1'b0};
        if (b[2]) p = p ^ {1'b0, a, 2'b00};
        if (b[3]) p = p ^ {a, 3'b000};
        if (p[6]) p = p ^ 7'b1001100;
        if (p[5]) p = p ^ 7'b0100110;
        if (p[4]) p = p ^ 7'b0010011;
        return p[3:0];
    endfunction

    function automatic logic [11:0] share3(input logic [3:0] v);
        logic [3:0] r0, r1;
        r0 = 4'($urandom);
        r1 = 4'($urandom);
        return {v ^ r0 ^ r1, r1, r0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_q2", 32'(q2), 32'd0);
        chk("rst_ov2", 32'(ov2), 32'd0);
        chk("rst_q4", 32'(q4), 32'd0);
        chk("rst_ov4", 32'(ov4), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        // X = 2 as (1,3), Y = 3 as (2,1): X*Y = 1
        x2 = {2'd3, 2'd1}; y2 = {2'd1, 2'd2}; b2 = '0; z2 = '0; mode2 = 1'b0; vin2 = 1'b1;
        step();
        chk("t1_ov", 32'(ov2), 32'd1);
        chk("t1_q", 32'(fold2(q2)), 32'd1);

        // Fused mode: 1 ^ 2*(2^3)^2 = 3 regardless of sharing/B/Z.
        for (int k = 0; k < 20; k++) begin
            r  = 2'($urandom);
            x2 = {r, r ^ 2'd2};
            r  = 2'($urandom);
            y2 = {r, r ^ 2'd3};
            b2 = 4'($urandom); z2 = 2'($urandom); mode2 = 1'b1; vin2 = 1'b1;
            step();
            chk("fused_ov", 32'(ov2), 32'd1);
            chk("fused_q", 32'(fold2(q2)), 32'd3);
        end

        for (int k = 0; k < 5; k++) begin
            x2 = {2'd3, 2'd1}; y2 = {2'd1, 2'd2};
            b2 = 4'($urandom); z2 = 2'($urandom);
            vin2 = vpat[k]; mode2 = mpat[k];
            step();
            chk("vpat_ov", 32'(ov2), 32'(vpat[k]));
            if (vpat[k]) chk("vpat_q", 32'(fold2(q2)), mpat[k] ? 32'd3 : 32'd1);
        end

        // Y = 3: products 1*3=3, 2*3=1, 3*3=2.
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                en = 1'b0;
                x2 = 4'hF; y2 = 4'h5; b2 = 4'hA; mode2 = 1'b1; vin2 = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("stall_ov", 32'(ov2), 32'd1);
                    chk("stall_q", 32'(fold2(q2)), 32'(st_e[1]));
                end
                en = 1'b1;
            end
            x2 = {2'd1, st_x[k] ^ 2'd1}; y2 = {2'd1, 2'd2};
            b2 = 4'($urandom); z2 = 2'($urandom); mode2 = 1'b0; vin2 = 1'b1;
            step();
            chk("stream_ov", 32'(ov2), 32'd1);
            chk("stream_q", 32'(fold2(q2)), 32'(st_e[k]));
        end
        vin2 = 1'b0;

        // GF(16): 2 * 9 = 1 at latency 2.
        for (int k = 0; k < 1000; k++) begin
            x4 = share3(4'h2); y4 = share3(4'h9);
            b4 = 12'($urandom); z4 = 12'($urandom); mode4 = 1'b0; vin4 = 1'b1;
            step();
            if (k == 0) begin
                chk("g16_first_ov", 32'(ov4), 32'd0);
            end else begin
                chk("g16_ov", 32'(ov4), 32'd1);
                chk("g16_q", 32'(fold4(q4)), 32'h1);
            end
        end

        // Fused: 1 ^ 9*(0xB)^2 = 1 ^ 9*9 = 1 ^ 0xD = 0xC.
        x4 = share3(4'h2); y4 = share3(4'h9);
        b4 = 12'($urandom); z4 = 12'($urandom); mode4 = 1'b1; vin4 = 1'b1;
        step();
        vin4 = 1'b0; mode4 = 1'b0;
        step();
        chk("g16_fused_ov", 32'(ov4), 32'd1);
        chk("g16_fused_q", 32'(fold4(q4)), 32'hC);

        for (int k = 0; k < 258; k++) begin
            if (k < 256) begin
                xv = 4'(k >> 4);
                yv = 4'(k);
                mode4 = 1'($urandom);
                sweep_exp[k] = ref_mul4(xv, yv) ^
                               (mode4 ? ref_mul4(ref_mul4(xv ^ yv, xv ^ yv), 4'h9) : 4'h0);
                x4 = share3(xv); y4 = share3(yv);
                b4 = 12'($urandom); z4 = 12'($urandom); vin4 = 1'b1;
            end else begin
                vin4 = 1'b0;
            end
            step();
            if (k >= 1 && k <= 256) begin
                chk("sweep_ov", 32'(ov4), 32'd1);
                chk("sweep_q", 32'(fold4(q4)), 32'(sweep_exp[k-1]));
            end else if (k == 257) begin
                chk("sweep_tail_ov", 32'(ov4), 32'd0);
            end
        end

        // Two operations in flight, then asynchronous reset mid-cycle.
        x4 = share3(4'h2); y4 = share3(4'h9);
        b4 = 12'($urandom); z4 = 12'($urandom); mode4 = 1'b0; vin4 = 1'b1;
        step();
        x4 = share3(4'h3); y4 = share3(4'h7);
        step();
        chk("inflight_ov", 32'(ov4), 32'd1);
        chk("inflight_q", 32'(fold4(q4)), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_q4", 32'(q4), 32'd0);
        chk("arst_ov4", 32'(ov4), 32'd0);
        chk("arst_q2", 32'(q2), 32'd0);
        chk("arst_ov2", 32'(ov2), 32'd0);
        x4 = '0; y4 = '0; b4 = '0; z4 = '0; vin4 = 1'b0;
        x2 = '0; y2 = '0; b2 = '0; z2 = '0; vin2 = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_ov4", 32'(ov4), 32'd0);
            chk("post_rst_q4", 32'(q4), 32'd0);
            chk("post_rst_ov2", 32'(ov2), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
